// File: rtl/rle1_pkg.sv
// Shared definitions for the rle1 encoder/decoder pair.
//
// Token layout (TOK_W bits): { cnt[CNT_W-1:0], sym[SYM_W-1:0] }
//   sym : symbol value, passed through uninterpreted
//   cnt : unsigned run length (0 is a legal, empty run)
package rle1_pkg;

  localparam int SYM_W = 2;
  localparam int CNT_W = 4;
  localparam int TOK_W = SYM_W + CNT_W;

  // Field slice positions within a flat token vector.
  localparam int SYM_LSB = 0;
  localparam int SYM_MSB = SYM_W - 1;
  localparam int CNT_LSB = SYM_W;
  localparam int CNT_MSB = TOK_W - 1;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [SYM_W-1:0] sym;
  } rle1_tok_t;

  function automatic rle1_tok_t rle1_tok_pack(input logic [CNT_W-1:0] cnt,
                                              input logic [SYM_W-1:0] sym);
    rle1_tok_t t;
    t.cnt = cnt;
    t.sym = sym;
    return t;
  endfunction

endpackage

// File: rtl/rle1_dec_wrap.sv
// rle1_dec_wrap: hardening wrapper around rle1_dec. Adds the optional
// vdd/vss power pins so the macro boundary matches the encoder's wrapper.
// All decoder behaviour lives in rle1_dec.
//
// Ports: as rle1_dec, plus vdd/vss when USE_POWER_PINS is defined.
module rle1_dec_wrap #(
  parameter int SYM_W = rle1_pkg::SYM_W,
  parameter int CNT_W = rle1_pkg::CNT_W
) (
`ifdef USE_POWER_PINS
  inout  wire                    vdd,
  inout  wire                    vss,
`endif
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SYM_W+CNT_W-1:0] rle1_dec__input_r,
  input  logic                   rle1_dec__input_r_vld,
  output logic                   rle1_dec__input_r_rdy,
  output logic [SYM_W-1:0]       rle1_dec__output_s,
  output logic                   rle1_dec__output_s_vld,
  input  logic                   rle1_dec__output_s_rdy
);

  rle1_dec #(
    .SYM_W (SYM_W),
    .CNT_W (CNT_W)
  ) u_rle1_dec (
    .clk                    (clk),
    .reset                  (reset),
    .rle1_dec__input_r      (rle1_dec__input_r),
    .rle1_dec__input_r_vld  (rle1_dec__input_r_vld),
    .rle1_dec__input_r_rdy  (rle1_dec__input_r_rdy),
    .rle1_dec__output_s     (rle1_dec__output_s),
    .rle1_dec__output_s_vld (rle1_dec__output_s_vld),
    .rle1_dec__output_s_rdy (rle1_dec__output_s_rdy)
  );

endmodule

// File: rtl/rle1_dec.sv
// rle1_dec: run-length decoder. Expands {count, symbol} tokens into a stream
// of symbols, one per accepted output beat, with no bubbles between runs.
//
// Ports:
//   clk                     clock, rising edge
//   reset                   synchronous, active-high
//   rle1_dec__input_r       token {cnt, sym}
//   rle1_dec__input_r_vld   token valid
//   rle1_dec__input_r_rdy   decoder takes a token this cycle
//   rle1_dec__output_s      decoded symbol (registered)
//   rle1_dec__output_s_vld  symbol valid (registered)
//   rle1_dec__output_s_rdy  downstream accepts symbol
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no run held; output invalid, ready for a token
// RUN   | presenting sym_q; rem_q beats left including the current one
module rle1_dec #(
  parameter int SYM_W = rle1_pkg::SYM_W,
  parameter int CNT_W = rle1_pkg::CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SYM_W+CNT_W-1:0] rle1_dec__input_r,
  input  logic                   rle1_dec__input_r_vld,
  output logic                   rle1_dec__input_r_rdy,
  output logic [SYM_W-1:0]       rle1_dec__output_s,
  output logic                   rle1_dec__output_s_vld,
  input  logic                   rle1_dec__output_s_rdy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic [SYM_W-1:0] tok_sym;
  logic [CNT_W-1:0] tok_cnt;
  logic             tok_nonzero;
  logic             last_beat;
  logic             in_xfer;
  logic             out_xfer;

  assign tok_sym     = rle1_dec__input_r[SYM_W-1:0];
  assign tok_cnt     = rle1_dec__input_r[SYM_W+CNT_W-1:SYM_W];
  assign tok_nonzero = (tok_cnt != '0);
  assign last_beat   = (rem_q == CNT_W'(1));

  // Outputs come straight from registers so they hold steady under stall.
  assign rle1_dec__output_s     = sym_q;
  assign rle1_dec__output_s_vld = (state_q == RUN);

  // Ready on the last beat depends on output_s_rdy so the next token can be
  // loaded in the same cycle the last symbol leaves (no bubble). Nothing
  // here looks at input_r_vld.
  always_comb begin
    rle1_dec__input_r_rdy = 1'b0;
    if (!reset) begin
      rle1_dec__input_r_rdy = (state_q == IDLE) ||
                              ((state_q == RUN) && last_beat && rle1_dec__output_s_rdy);
    end
  end

  assign in_xfer  = rle1_dec__input_r_vld && rle1_dec__input_r_rdy;
  assign out_xfer = rle1_dec__output_s_vld && rle1_dec__output_s_rdy;

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        // Zero-count tokens are swallowed without leaving IDLE.
        if (in_xfer && tok_nonzero) begin
          state_d = RUN;
          sym_d   = tok_sym;
          rem_d   = tok_cnt;
        end
      end
      RUN: begin
        if (out_xfer) begin
          if (!last_beat) begin
            rem_d = rem_q - CNT_W'(1);
          end else if (in_xfer && tok_nonzero) begin
            sym_d = tok_sym;
            rem_d = tok_cnt;
          end else begin
            state_d = IDLE;
            rem_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sym_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: doc/rle1_dec.md
# rle1_dec

Run-length decoder for the 1-bit-class RLE stream: consumes 6-bit `{count, symbol}` tokens produced by `rle1_enc` and re-expands them into a stream of 2-bit symbols, one symbol per accepted output beat. It sits directly downstream of the encoder. It is used both as the loopback checker in the tapeout test harness and as the playback stage feeding the bytebeat sample path. It has valid/ready handshakes on both sides and sustains one symbol per cycle across token boundaries.

## Interface
- `SYM_W`, default 2: symbol width.
- `CNT_W`, default 4: run-length field width; token width is `SYM_W+CNT_W` (6).
- `clk` (in, 1): single clock; all state changes on the rising edge.
- `reset` (in, 1): synchronous, active-high.
- `rle1_dec__input_r` (in, 6): token; `[1:0]` is the symbol, `[5:2]` is the run count (unsigned).
- `rle1_dec__input_r_vld` (in, 1): token valid.
- `rle1_dec__input_r_rdy` (out, 1): decoder can take a token this cycle.
- `rle1_dec__output_s` (out, 2): decoded symbol.
- `rle1_dec__output_s_vld` (out, 1): symbol valid.
- `rle1_dec__output_s_rdy` (in, 1): downstream accepts symbol.

## Operation
- The input transfer is `input_r_vld & input_r_rdy`; the output transfer is `output_s_vld & output_s_rdy`.
- State:
  - `sym_q` (SYM_W): current symbol.
  - `rem_q` (CNT_W): symbols still to emit, including the one currently presented.
  - FSM `IDLE` / `RUN`.
- IDLE:
  - `output_s_vld=0`, `input_r_rdy=1`.
  - Token accepted with count ≥1: `sym_q<=symbol`, `rem_q<=count`, go to RUN.
  - Token accepted with count 0: dropped, stay in IDLE.
- RUN:
  - `output_s_vld=1` and `output_s=sym_q`, both driven from registers.
  - Output transfer with `rem_q>1`: `rem_q<=rem_q-1`.
  - Output transfer with `rem_q==1` (last beat): reload from the input if an input transfer happens in the same cycle (count ≥1 goes to RUN with the new values; count 0 goes to IDLE). With no input transfer, go to IDLE.
  - No output transfer: hold all state; `sym_q`/`output_s` stay stable.
- `input_r_rdy = (state==IDLE) | (state==RUN & rem_q==1 & output_s_rdy)`. This is a combinational path from `output_s_rdy`; there is no combinational path from `input_r_vld` to any output.
- `rem_q` never underflows. Count 15 yields exactly 15 output beats.
- Symbol values pass through unmodified, with no interpretation.

## Timing
- Reset, while `reset` is high and on the first cycle after it:
  - State is IDLE; `sym_q=0`, `rem_q=0`.
  - Outputs: `output_s=0`, `output_s_vld=0`.
  - `input_r_rdy` is forced to 0 while `reset` is high and is 1 on the first cycle after reset deasserts.
- Reset mid-run: the remaining symbols of the held token are discarded, with no partial output afterward.
- Latency: a token accepted at edge N presents its first symbol from cycle N+1.
- Throughput: with `output_s_rdy` held at 1 and tokens always valid, output is continuous with zero bubbles between runs. A run of count C occupies exactly C output cycles.
- A count-0 token accepted on a last beat produces a one-cycle gap (IDLE), then normal operation.
- Backpressure: `output_s` and `output_s_vld` are stable while `vld & !rdy`. Once asserted, `output_s_vld` is deasserted only by a transfer or by reset.

## Structure
- Shared package `rle1_pkg`, also to be adopted by `rle1_enc`, holding:
  - `SYM_W`, `CNT_W`, `TOK_W`.
  - Token typedef `rle1_tok_t` with packed fields `{cnt, sym}`.
  - Field-slice constants.
- FSM state enum local to `rle1_dec`.
- One sub-module: `rle1_dec_wrap`, a thin wrapper with the `USE_POWER_PINS` `vdd`/`vss` ports, matching the encoder's wrapper for macro hardening. Decoder logic lives entirely in `rle1_dec`.

## Test plan
- **Reset:** hold `reset` 3 cycles with `input_r_vld=1` → `input_r_rdy=0`, `output_s_vld=0`, `output_s=0`. Cycle after release: `input_r_rdy=1`.
- **Single token:** token `{cnt=3, sym=2'b10}` (6'b001110), `output_s_rdy=1` → `output_s=2'b10` valid on exactly 3 consecutive cycles starting one cycle after acceptance, then `vld=0`.
- **Back-to-back:** tokens `{2,01}`, `{1,11}`, `{15,00}` streamed with `rdy=1` → 18 consecutive valid beats `01,01,11,00×15` with no gaps. `input_r_rdy` is high only on each run's last beat.
- **Backpressure:** token `{4,11}`, `output_s_rdy` toggling `1,0,0,1,0,1,1` → exactly 4 transfers of `11`. Output stable while stalled. No new token accepted until the 4th transfer cycle.
- **Zero count:** tokens `{0,10}`, then `{2,01}` → `{0,10}` is consumed with no output; exactly two `01` beats follow. A `{0,xx}` token loaded on a last beat yields a single-cycle `vld=0` gap.
- **Loopback and reset mid-run:**
  - Loopback: random 2-bit stream → `rle1_enc` → `rle1_dec` reproduces the stream exactly under random backpressure on both ends.
  - Reset mid-run: `reset` asserted during the 2nd beat of `{5,01}` → no further `01` beats after reset.
